vec_wb_collector: RTL

//  Receive end of the 4-lane vector ALU result interface. Per-lane chunks (vdN) arrive at
//  per-lane bit offsets (regiN); the block assembles them into one VLEN-bit destination

---
 rtl/vec_pkg.sv | 32 +++
 rtl/vec_wb_lane_merge.sv | 39 +++
 rtl/vec_wb_collector.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: op-type and SEW codes, the write-back
// collector state encoding and the lane chunk-width helper.
package vec_pkg;

  localparam logic [1:0] OP_VV = 2'd0;
  localparam logic [1:0] OP_VX = 2'd1;
  localparam logic [1:0] OP_VI = 2'd2;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  // Chunk width in bits is the element width capped at the lane width;
  // an illegal SEW code yields 0 so no capture can happen.
  function automatic logic [7:0] chunk_width(input logic [2:0] vsew,
                                             input logic [2:0] lane_width);
    logic [7:0] sew_w;
    logic [7:0] lane_w;
    if (vsew > SEW_64) return 8'd0;
    sew_w  = 8'd8 << vsew;
    lane_w = 8'd1 << lane_width;
    return (sew_w < lane_w) ? sew_w : lane_w;
  endfunction

endpackage

// File: rtl/vec_wb_lane_merge.sv
// Merges one lane chunk into the register image and byte mask; flags the
// chunk as dropped when it would run past the end of the register.
module vec_wb_lane_merge #(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0]   data_i,
  input  logic [VLEN/8-1:0] mask_i,
  input  logic              valid_i,
  input  logic [63:0]       chunk_i,
  input  logic [9:0]        off_i,
  input  logic [7:0]        width_i,
  output logic [VLEN-1:0]   data_o,
  output logic [VLEN/8-1:0] mask_o,
  output logic              drop_o
);

  logic [63:0]     width_bits;
  logic [VLEN-1:0] bit_sel;
  logic [VLEN-1:0] chunk_pos;
  logic            in_range;

  always_comb begin
    width_bits = (64'd1 << width_i) - 64'd1;
    in_range   = (32'(off_i) + 32'(width_i)) <= 32'(VLEN);
    drop_o     = valid_i && !in_range;
    bit_sel    = VLEN'(width_bits) << off_i;
    chunk_pos  = VLEN'(chunk_i & width_bits) << off_i;
    data_o     = data_i;
    mask_o     = mask_i;
    // Only the chunk's own bits change; a byte is enabled if any of its bits is touched.
    if (valid_i && in_range) begin
      data_o = (data_i & ~bit_sel) | chunk_pos;
      for (int j = 0; j < VLEN / 8; j++) begin
        if (|bit_sel[8*j +: 8]) mask_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_wb_collector.sv
// Collects per-lane ALU result chunks into one destination register image
// with byte enables and hands it to the VRF over a valid/ready write port.
module vec_wb_collector
  import vec_pkg::*;
#(
  parameter int          VLEN       = 128,
  parameter logic [2:0]  LANE_WIDTH = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        vd_addr,
  input  logic [2:0]        vsew,
  input  logic [3:0]        lane_valid,
  input  logic [63:0]       vd0,
  input  logic [63:0]       vd1,
  input  logic [63:0]       vd2,
  input  logic [63:0]       vd3,
  input  logic [9:0]        regi0,
  input  logic [9:0]        regi1,
  input  logic [9:0]        regi2,
  input  logic [9:0]        regi3,
  input  logic              done_in,
  output logic              busy,
  output logic              vrf_wr_valid,
  input  logic              vrf_wr_ready,
  output logic [4:0]        vrf_wr_addr,
  output logic [VLEN-1:0]   vrf_wr_data,
  output logic [VLEN/8-1:0] vrf_wr_be,
  output logic              err
);

  state_e            state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic [2:0]        vsew_q, vsew_d;
  logic [VLEN-1:0]   data_q, data_d;
  logic [VLEN/8-1:0] mask_q, mask_d;
  logic              err_q, err_d;

  logic [63:0]       lane_vd   [4];
  logic [9:0]        lane_off  [4];
  logic [VLEN-1:0]   chain_data[5];
  logic [VLEN/8-1:0] chain_mask[5];
  logic [3:0]        lane_drop;
  logic              capture_en;
  logic [7:0]        width;

  assign lane_vd[0]  = vd0;
  assign lane_vd[1]  = vd1;
  assign lane_vd[2]  = vd2;
  assign lane_vd[3]  = vd3;
  assign lane_off[0] = regi0;
  assign lane_off[1] = regi1;
  assign lane_off[2] = regi2;
  assign lane_off[3] = regi3;

  assign capture_en    = (state_q == COLLECT) && (vsew_q <= SEW_64);
  assign width         = chunk_width(vsew_q, LANE_WIDTH);
  assign chain_data[0] = data_q;
  assign chain_mask[0] = mask_q;

  // Lanes are chained in ascending order so a higher lane overwrites a lower one.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    vec_wb_lane_merge #(.VLEN(VLEN)) u_merge (
      .data_i  (chain_data[k]),
      .mask_i  (chain_mask[k]),
      .valid_i (capture_en && lane_valid[k]),
      .chunk_i (lane_vd[k]),
      .off_i   (lane_off[k]),
      .width_i (width),
      .data_o  (chain_data[k+1]),
      .mask_o  (chain_mask[k+1]),
      .drop_o  (lane_drop[k])
    );
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    vsew_d  = vsew_q;
    data_d  = data_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          addr_d  = vd_addr;
          vsew_d  = vsew;
          data_d  = '0;
          mask_d  = '0;
          err_d   = (vsew > SEW_64);
        end
      end
      COLLECT: begin
        data_d = chain_data[4];
        mask_d = chain_mask[4];
        err_d  = err_q | (|lane_drop);
        if (done_in) state_d = WRITE;
      end
      WRITE: begin
        if (vrf_wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      vsew_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vsew_q  <= vsew_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign vrf_wr_valid = (state_q == WRITE);
  assign vrf_wr_addr  = addr_q;
  assign vrf_wr_data  = data_q;
  assign vrf_wr_be    = mask_q;
  assign err          = err_q;

endmodule
